stream_fifo: RTL and testbench

- Synchronous valid/ready FIFO that buffers words between a stream producer and a stream consumer.
- Sits between the stream generator's down port and the stream checker's up port.
- Decouples producer and consumer stall patterns.
- Output is first-word-fall-through from registered state, with no combinational path from up_* to down_*.

---
 rtl/stream_fifo.sv | 84 ++++++++
 tb/tb_stream_fifo.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/stream_fifo.sv
// stream_fifo: synchronous valid/ready FIFO between a stream producer and a
// stream consumer. Output is first-word-fall-through, driven only from
// registered state (pointers, level, storage), so nothing on up_* reaches
// down_* combinationally.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   up_valid    producer has a word on up_data
//   up_data     producer data (DW bits)
//   up_ready    FIFO accepts a word this cycle (registered)
//   down_valid  FIFO presents a word on down_data (level != 0)
//   down_data   head-of-FIFO word, mem[rd_ptr]
//   down_ready  consumer accepts the word this cycle
//   level       words currently stored, 0..DEPTH (AW+1 bits)
module stream_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          up_valid,
  input  logic [DW-1:0] up_data,
  output logic          up_ready,
  output logic          down_valid,
  output logic [DW-1:0] down_data,
  input  logic          down_ready,
  output logic [AW:0]   level
);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("stream_fifo: DEPTH must be a power of 2 and at least 2");
  end

  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          r_up_ready;

  logic          w_push;
  logic          w_pop;
  logic [AW:0]   w_level_next;

  assign w_push = up_valid && r_up_ready;
  assign w_pop  = down_valid && down_ready;

  always_comb begin
    w_level_next = r_level;
    w_level_next = r_level + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
  end

  // Control state: pointers, level and the registered ready. Reset clears
  // these asynchronously so down_valid and up_ready fall with rst; up_ready
  // comes back one edge after release because level_next is then 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_up_ready <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level    <= w_level_next;
      r_up_ready <= (w_level_next != LVL_FULL);
    end
  end

  // Storage: data only, never reset. Stale entries are unreachable after a
  // reset because level restarts at 0.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= up_data;
  end

  assign up_ready   = r_up_ready;
  assign down_valid = (r_level != '0);
  assign down_data  = r_mem[r_rd_ptr];
  assign level      = r_level;

endmodule

// File: tb/tb_stream_fifo.sv
module tb_stream_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          up_valid;
  logic [DW-1:0] up_data;
  logic          up_ready;
  logic          down_valid;
  logic [DW-1:0] down_data;
  logic          down_ready;
  logic [AW:0]   level;

  int tests = 0;
  int fails = 0;

  stream_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (up_valid),
    .up_data    (up_data),
    .up_ready   (up_ready),
    .down_valid (down_valid),
    .down_data  (down_data),
    .down_ready (down_ready),
    .level      (level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_wr;
    int exp_rd;
    int mlevel;
    int cycles;
    logic       push_now;
    logic       pop_now;
    logic       hold_chk;
    logic [31:0] hold_data;

    rst = 1'b1; up_valid = 1'b0; up_data = '0; down_ready = 1'b0;
    step(); step();
    chk("rst_up_ready",   32'(up_ready),   32'd0);
    chk("rst_down_valid", 32'(down_valid), 32'd0);
    chk("rst_level",      32'(level),      32'd0);

    // Release between edges; up_ready rises on the following edge.
    rst = 1'b0;
    #2;
    chk("rel_up_ready_before_edge", 32'(up_ready), 32'd0);
    step();
    chk("rel_up_ready_after_edge", 32'(up_ready), 32'd1);
    chk("rel_down_valid", 32'(down_valid), 32'd0);

    // Single word: visible the cycle after the push, gone after the pop.
    up_valid = 1'b1; up_data = 32'hA5A5_0001; down_ready = 1'b1;
    step();
    up_valid = 1'b0;
    chk("single_down_valid", 32'(down_valid), 32'd1);
    chk("single_down_data",  down_data,       32'hA5A5_0001);
    chk("single_level1",     32'(level),      32'd1);
    step();
    chk("single_level0",     32'(level),      32'd0);
    chk("single_empty",      32'(down_valid), 32'd0);

    // Fill to full with 0..7, consumer stalled.
    down_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      up_valid = 1'b1; up_data = 32'(i);
      step();
      chk("fill_level", 32'(level), 32'(i + 1));
    end
    chk("full_up_ready", 32'(up_ready), 32'd0);
    up_data = 32'hFF;
    step();
    chk("full_reject_level", 32'(level),   32'd8);
    chk("full_head_data",    down_data,    32'd0);
    chk("full_still_valid",  32'(down_valid), 32'd1);

    // At full, push and pop offered together: only the pop happens.
    up_data = 32'd8; down_ready = 1'b1;
    step();
    chk("drain_level7",   32'(level),    32'd7);
    chk("drain_up_ready", 32'(up_ready), 32'd1);
    chk("drain_head",     down_data,     32'd1);
    down_ready = 1'b0;
    step();
    up_valid = 1'b0;
    chk("refill_level8", 32'(level), 32'd8);
    down_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("drain_order", down_data, 32'(i));
      step();
    end
    chk("drain_empty_level", 32'(level), 32'd0);
    chk("drain_empty_valid", 32'(down_valid), 32'd0);

    // Streaming 0..99 with both sides always ready.
    up_valid = 1'b1; up_data = 32'd0; down_ready = 1'b1;
    step();
    for (int i = 0; i < 100; i++) begin
      chk("stream_valid", 32'(down_valid), 32'd1);
      chk("stream_data",  down_data,       32'(i));
      chk("stream_level", 32'(level),      32'd1);
      if (i < 99) up_data = 32'(i + 1);
      else        up_valid = 1'b0;
      step();
    end
    chk("stream_end_level", 32'(level), 32'd0);

    // Random stalls: 1000 incrementing words, scoreboard on order and level.
    exp_wr = 0; exp_rd = 0; mlevel = 0; cycles = 0; hold_chk = 1'b0; hold_data = '0;
    while (exp_rd < 1000 && cycles < 20000) begin
      up_valid   = (exp_wr < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
      up_data    = 32'(exp_wr);
      down_ready = 1'($urandom_range(0, 1));
      #1;
      if (hold_chk) chk("rand_stable", down_data, hold_data);
      push_now = up_valid && up_ready;
      pop_now  = down_valid && down_ready;
      if (pop_now) begin
        chk("rand_data", down_data, 32'(exp_rd));
        exp_rd++;
      end
      hold_chk  = down_valid && !down_ready;
      hold_data = down_data;
      if (push_now) exp_wr++;
      mlevel = mlevel + int'(push_now) - int'(pop_now);
      step();
      cycles++;
      chk("rand_level", 32'(level), 32'(mlevel));
    end
    chk("rand_done_in_budget", 32'(exp_rd), 32'd1000);
    up_valid = 1'b0; down_ready = 1'b1;
    for (int i = 0; i < 16 && down_valid; i++) step();
    chk("rand_flushed", 32'(level), 32'd0);

    // Reset mid-stream with 5 words stored.
    down_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      up_valid = 1'b1; up_data = 32'h100 + 32'(i);
      step();
    end
    up_valid = 1'b0;
    chk("mid_level5", 32'(level), 32'd5);
    rst = 1'b1;
    #1;
    chk("mid_rst_down_valid", 32'(down_valid), 32'd0);
    chk("mid_rst_up_ready",   32'(up_ready),   32'd0);
    chk("mid_rst_level",      32'(level),      32'd0);
    step(); step();
    rst = 1'b0;
    chk("mid_rel_level", 32'(level), 32'd0);
    step();
    chk("mid_rel_up_ready", 32'(up_ready),   32'd1);
    chk("mid_rel_no_stale", 32'(down_valid), 32'd0);
    up_valid = 1'b1; up_data = 32'h1234; down_ready = 1'b1;
    step();
    up_valid = 1'b0;
    chk("mid_first_valid", 32'(down_valid), 32'd1);
    chk("mid_first_data",  down_data,       32'h1234);
    step();
    chk("mid_final_level", 32'(level), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
